// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
// Sequential 8-bit matrix multiplier C = A x B using a single 8x8 multiplier
// and a single 8-bit accumulator. Every product and sum wraps modulo 256.
// Operands are captured when a job starts. One MAC is performed per clock.
// C is loaded only on the edge that completes the final element.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request one multiplication (sampled in IDLE only)
//   abort  : synchronous cancel of a running job
//   A      : a x b matrix, element [r][p] at bits (r*b+p)*8 +: 8
//   B      : b x c matrix, element [r][p] at bits (r*c+p)*8 +: 8
//   C      : a x c registered result, element [r][p] at bits (r*c+p)*8 +: 8
//   busy   : high while a job is running
//   done   : one-cycle completion pulse
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int a = 3,
    parameter int b = 2,
    parameter int c = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [a*b*8-1:0]     A,
    input  logic [b*c*8-1:0]     B,
    output logic [a*c*8-1:0]     C,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = (a > 1) ? $clog2(a) : 1;
    localparam int KW = (b > 1) ? $clog2(b) : 1;
    localparam int JW = (c > 1) ? $clog2(c) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(a - 1);
    localparam logic [KW-1:0] K_LAST = KW'(b - 1);
    localparam logic [JW-1:0] J_LAST = JW'(c - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r;
    logic [7:0]    a_mat_r [a][b];
    logic [7:0]    b_mat_r [b][c];
    logic [7:0]    res_r   [a][c];
    logic [IW-1:0] i_r;
    logic [KW-1:0] k_r;
    logic [JW-1:0] j_r;
    logic [7:0]    acc_r;

    logic [15:0]   prod_s;
    logic [7:0]    mac_s;
    logic          last_k_s;
    logic          last_j_s;
    logic          last_i_s;

    // Single multiplier and accumulator adder; only the low byte of the product matters.
    always_comb begin
        prod_s   = 16'd0;
        mac_s    = 8'd0;
        prod_s   = a_mat_r[i_r][k_r] * b_mat_r[k_r][j_r];
        mac_s    = acc_r + prod_s[7:0];
        last_k_s = (k_r == K_LAST);
        last_j_s = (j_r == J_LAST);
        last_i_s = (i_r == I_LAST);
    end

    // Control FSM, operand capture, MAC sequencing and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            C       <= '0;
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
            acc_r   <= 8'd0;
            for (int r = 0; r < a; r++) begin
                for (int p = 0; p < b; p++) begin
                    a_mat_r[r][p] <= 8'd0;
                end
                for (int p = 0; p < c; p++) begin
                    res_r[r][p] <= 8'd0;
                end
            end
            for (int r = 0; r < b; r++) begin
                for (int p = 0; p < c; p++) begin
                    b_mat_r[r][p] <= 8'd0;
                end
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Abort is irrelevant here: a start in IDLE always wins.
                        for (int r = 0; r < a; r++) begin
                            for (int p = 0; p < b; p++) begin
                                a_mat_r[r][p] <= A[(r*b+p)*8 +: 8];
                            end
                        end
                        for (int r = 0; r < b; r++) begin
                            for (int p = 0; p < c; p++) begin
                                b_mat_r[r][p] <= B[(r*c+p)*8 +: 8];
                            end
                        end
                        i_r     <= '0;
                        j_r     <= '0;
                        k_r     <= '0;
                        acc_r   <= 8'd0;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // Cancelled job: C keeps its old value and no done pulse follows.
                        i_r     <= '0;
                        j_r     <= '0;
                        k_r     <= '0;
                        acc_r   <= 8'd0;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (last_k_s) begin
                        res_r[i_r][j_r] <= mac_s;
                        acc_r           <= 8'd0;
                        k_r             <= '0;
                        if (last_j_s) begin
                            j_r <= '0;
                            if (last_i_s) begin
                                // Final MAC: publish all elements, bypassing the last one
                                // since res_r does not hold it yet.
                                for (int r = 0; r < a; r++) begin
                                    for (int p = 0; p < c; p++) begin
                                        C[(r*c+p)*8 +: 8] <= res_r[r][p];
                                    end
                                end
                                C[(a*c-1)*8 +: 8] <= mac_s;
                                i_r     <= '0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state_r <= ST_DONE;
                            end else begin
                                i_r <= i_r + 1'b1;
                            end
                        end else begin
                            j_r <= j_r + 1'b1;
                        end
                    end else begin
                        acc_r <= mac_s;
                        k_r   <= k_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: jobs push expected C into a queue,
// an independent monitor pops and compares on every done pulse.
module tb_matmul_seq_ctrl;

    localparam int NA = 3;
    localparam int NB = 2;
    localparam int NC = 6;
    localparam int AW = NA*NB*8;
    localparam int BW = NB*NC*8;
    localparam int CW = NA*NC*8;

    localparam int MODE_NORMAL  = 0;
    localparam int MODE_RESTART = 1;
    localparam int MODE_ABORT   = 2;
    localparam int MODE_RESET   = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] a_in;
    logic [BW-1:0] b_in;
    logic [CW-1:0] c_out;
    logic          busy;
    logic          done;

    int            tests;
    int            failed;
    logic [CW-1:0] exp_q [$];
    logic [CW-1:0] last_c;

    matmul_seq_ctrl #(.a(NA), .b(NB), .c(NC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .A     (a_in),
        .B     (b_in),
        .C     (c_out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] fill_a(input logic [7:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < NA*NB; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [BW-1:0] fill_b(input logic [7:0] v);
        logic [BW-1:0] r;
        for (int i = 0; i < NB*NC; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [CW-1:0] fill_c(input logic [7:0] v);
        logic [CW-1:0] r;
        for (int i = 0; i < NA*NC; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    // Combinational reference: plain triple loop, everything modulo 256.
    function automatic logic [CW-1:0] model(input logic [AW-1:0] av, input logic [BW-1:0] bv);
        logic [CW-1:0] r;
        logic [7:0]    acc;
        logic [7:0]    x;
        logic [7:0]    y;
        logic [15:0]   pr;
        for (int i = 0; i < NA; i++) begin
            for (int j = 0; j < NC; j++) begin
                acc = 8'd0;
                for (int k = 0; k < NB; k++) begin
                    x   = av[(i*NB+k)*8 +: 8];
                    y   = bv[(k*NC+j)*8 +: 8];
                    pr  = x * y;
                    acc = acc + pr[7:0];
                end
                r[(i*NC+j)*8 +: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] req);
        tests++;
        if (got !== req) begin
            failed++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_done: got done=1 required no pulse");
            end else begin
                logic [CW-1:0] e;
                e = exp_q.pop_front();
                if (c_out !== e) begin
                    failed++;
                    $display("FAIL result: got C=%h required %h", c_out, e);
                end
            end
        end
    end

    task automatic run_job(input logic [AW-1:0] av, input logic [BW-1:0] bv,
                           input logic [CW-1:0] exp_c, input int mode, input int poke_edge);
        int n;
        int busy_cnt;
        int c_changes;
        busy_cnt  = 0;
        c_changes = 0;
        @(negedge clk);
        a_in  = av;
        b_in  = bv;
        start = 1'b1;
        if (mode == MODE_NORMAL || mode == MODE_RESTART) exp_q.push_back(exp_c);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_edge0", CW'(busy), CW'(1'b1));
        for (n = 1; n <= 60; n++) begin
            if (n == poke_edge) begin
                @(negedge clk);
                if (mode == MODE_RESTART) begin
                    start = 1'b1;
                    a_in  = fill_a(8'h0F);
                    b_in  = fill_b(8'h11);
                end else if (mode == MODE_ABORT) begin
                    abort = 1'b1;
                end else if (mode == MODE_RESET) begin
                    rst_n = 1'b0;
                    #1;
                    check("reset_c_immediate", c_out, '0);
                    check("reset_busy_immediate", CW'(busy), CW'(1'b0));
                    check("reset_done_immediate", CW'(done), CW'(1'b0));
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                    rst_n  = 1'b1;
                    last_c = '0;
                    repeat (45) @(posedge clk);
                    #1;
                    check("busy_after_reset_job", CW'(busy), CW'(1'b0));
                    return;
                end
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (mode == MODE_ABORT && n == poke_edge) begin
                abort = 1'b0;
                check("abort_busy", CW'(busy), CW'(1'b0));
                check("abort_c_kept", c_out, last_c);
                repeat (45) @(posedge clk);
                #1;
                check("abort_c_still_kept", c_out, last_c);
                return;
            end
            if (done) break;
            if (busy) busy_cnt++;
            if (c_out !== last_c) c_changes++;
        end
        check("done_edge", CW'(n), CW'(NA*NB*NC));
        check("busy_cycles", CW'(busy_cnt), CW'(NA*NB*NC-1));
        check("c_stable_in_run", CW'(c_changes), '0);
        @(posedge clk);
        #1;
        check("done_one_cycle", CW'(done), CW'(1'b0));
        check("busy_after_done", CW'(busy), CW'(1'b0));
        last_c = exp_c;
    endtask

    initial begin
        logic [AW-1:0] pa;
        logic [BW-1:0] pb;
        logic [CW-1:0] ec;
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        last_c = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_c", c_out, '0);
        check("reset_busy", CW'(busy), CW'(1'b0));
        check("reset_done", CW'(done), CW'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // All ones: each element is 1*1 + 1*1.
        run_job(fill_a(8'h01), fill_b(8'h01), fill_c(8'h02), MODE_NORMAL, 0);

        // Single non-zero product lands in C[0][0] only.
        pa = '0; pa[7:0] = 8'h03;
        pb = '0; pb[7:0] = 8'h05;
        ec = '0; ec[7:0] = 8'h0F;
        run_job(pa, pb, ec, MODE_NORMAL, 0);

        // 0x10*0x10 = 0x100 wraps to zero.
        run_job(fill_a(8'h10), fill_b(8'h10), fill_c(8'h00), MODE_NORMAL, 0);

        // 0x0F*0x11 = 0xFF, two of them sum to 0x1FE -> 0xFE.
        run_job(fill_a(8'h0F), fill_b(8'h11), fill_c(8'hFE), MODE_NORMAL, 0);

        // Distinct elements everywhere to expose index-order or packing errors.
        for (int r = 0; r < NA; r++)
            for (int p = 0; p < NB; p++) pa[(r*NB+p)*8 +: 8] = 8'(r*7 + p*3 + 1);
        for (int r = 0; r < NB; r++)
            for (int p = 0; p < NC; p++) pb[(r*NC+p)*8 +: 8] = 8'(r*13 + p*5 + 2);
        run_job(pa, pb, model(pa, pb), MODE_NORMAL, 0);

        // Second start with new operands at edge 10 must be ignored.
        run_job(fill_a(8'h01), fill_b(8'h01), fill_c(8'h02), MODE_RESTART, 10);

        // Reset mid-job.
        run_job(fill_a(8'h0F), fill_b(8'h11), fill_c(8'hFE), MODE_RESET, 20);

        // Fresh result so the abort below has a non-zero value to preserve.
        for (int r = 0; r < NA; r++)
            for (int p = 0; p < NB; p++) pa[(r*NB+p)*8 +: 8] = 8'(r*41 + p*29 + 200);
        for (int r = 0; r < NB; r++)
            for (int p = 0; p < NC; p++) pb[(r*NC+p)*8 +: 8] = 8'(r*17 + p*23 + 150);
        run_job(pa, pb, model(pa, pb), MODE_NORMAL, 0);

        // Abort mid-job keeps the previous C.
        run_job(fill_a(8'h01), fill_b(8'h01), fill_c(8'h02), MODE_ABORT, 20);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", CW'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
